sync_fifo_sa: RTL and testbench
===============================

SYNC_FIFO_SA -- requirements
Module: sync_fifo_sa

Interface
REQ-001 SHALL have parameter LOG_DEPTH, default 3, meaning address width; capacity is 2**LOG_DEPTH words, every slot usable.
REQ-002 SHALL have parameter WIDTH, default 8, meaning data word width.
REQ-003 SHALL have parameter ALMOST_FULL_VALUE, default 6, meaning the usedw threshold for almost_full.
REQ-004 SHALL have parameter ALMOST_EMPTY_VALUE, default 2, meaning the usedw threshold for almost_empty.
REQ-005 SHALL have parameter SHOW_AHEAD, default 0, where 0 is normal read mode and 1 is first-word-fall-through mode.
REQ-006 SHALL have parameters OVERFLOW_CHECKING and UNDERFLOW_CHECKING, default 1 each, where 1 blocks illegal accesses.
REQ-007 SHALL have port clock, input, 1 bit: the single clock.
REQ-008 SHALL have port aclr_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-009 SHALL have port sclr, input, 1 bit: synchronous clear, active-high.
REQ-010 SHALL have ports wrreq (input, 1 bit) and data (input, WIDTH bits): the write request and write word.
REQ-011 SHALL have ports rdreq (input, 1 bit) and q (output, WIDTH bits): the read request (or acknowledge in show-ahead mode) and the read word.
REQ-012 SHALL have outputs empty, full, almost_empty and almost_full, 1 bit each, all registered.
REQ-013 SHALL have output usedw, LOG_DEPTH+1 bits: the registered word count, ranging 0..2**LOG_DEPTH.
REQ-014 SHALL have outputs overflow and underflow, 1 bit each: sticky error flags.

Function
REQ-015 SHALL define a write as accepted when wrreq=1 and (full=0, or rdreq accepted in the same cycle, or OVERFLOW_CHECKING=0).
REQ-016 SHALL define a read as accepted when rdreq=1 and (empty=0 or UNDERFLOW_CHECKING=0).
REQ-017 SHALL update usedw each cycle to usedw + accepted write - accepted read, using LOG_DEPTH+1-bit arithmetic.
REQ-018 SHALL hold read and write pointers of LOG_DEPTH bits each, wrapping modulo 2**LOG_DEPTH, and advance them only on accepted operations.
REQ-019 SHALL drive flags from the next usedw value, so the flags change in the same cycle as usedw with no lag: empty = (usedw==0); full = (usedw==2**LOG_DEPTH); almost_empty = (usedw<ALMOST_EMPTY_VALUE); almost_full = (usedw>=ALMOST_FULL_VALUE).
REQ-020 SHALL, when SHOW_AHEAD=0, update q on the cycle after an accepted read and hold q otherwise.
REQ-021 SHALL, when SHOW_AHEAD=1, present the head word on q whenever empty=0, with rdreq popping it and the next word appearing on the following cycle.
REQ-022 SHALL, when SHOW_AHEAD=1 and a word is written into an empty FIFO, show that word on q and deassert empty on the cycle after the write, using a write-through bypass.
REQ-023 SHALL, when full and wrreq=rdreq=1, perform both operations, leaving usedw unchanged.
REQ-024 SHALL, when empty and wrreq=rdreq=1 with UNDERFLOW_CHECKING=1, ignore the read and accept the write, giving usedw=1.
REQ-025 SHALL set overflow when wrreq=1, full=1 and rdreq=0, and SHALL set underflow when rdreq=1 and empty=1, in either checking mode.
REQ-026 SHALL hold overflow and underflow set until reset or sclr.
REQ-027 SHALL produce unchecked accesses that corrupt pointers without X-propagation, with usedw wrapping modulo 2**(LOG_DEPTH+1).

Reset
REQ-028 SHALL, on aclr_n=0, immediately clear both pointers, usedw, q, overflow, underflow, full and almost_full, and set empty=1 and almost_empty=(ALMOST_EMPTY_VALUE>0).
REQ-029 SHALL, on sclr=1 at a clock edge, apply the same values as reset and discard any simultaneous wrreq or rdreq.
REQ-030 SHALL NOT reset the memory array contents.
REQ-031 SHALL, after aclr_n deasserts, accept a wrreq on the first following clock edge.

Structure
REQ-032 SHALL place shared constants in package fifo_pkg: the count-width function clog2-based helper and the flag-threshold legality check (ALMOST_FULL_VALUE ≤ 2**LOG_DEPTH, ALMOST_EMPTY_VALUE ≤ ALMOST_FULL_VALUE).
REQ-033 SHALL contain exactly one sub-module, generic_mlab_sc: a single-clock simple-dual-port RAM with a registered read.
REQ-034 SHALL implement show-ahead prefetch and bypass logic in sync_fifo_sa itself.

Verification (LOG_DEPTH=3, WIDTH=8)
REQ-035 SHALL test fill and drain: write 0x01..0x08 -> full=1 after the 8th, usedw=8, almost_full from usedw=6; read 8 -> q=0x01..0x08 in order, empty=1.
REQ-036 SHALL test overflow: when full, wrreq=1 with data=0xAA -> write dropped, overflow=1 sticky, contents unchanged; then sclr -> overflow=0, usedw=0.
REQ-037 SHALL test simultaneous access: when full, wrreq=rdreq=1 -> usedw stays 8; when empty, wrreq=rdreq=1 -> usedw=1, underflow=1, q unchanged in normal mode.
REQ-038 SHALL test show-ahead: with SHOW_AHEAD=1, write 0x5C into an empty FIFO -> next cycle empty=0 and q=0x5C before any rdreq; rdreq -> empty=1.
REQ-039 SHALL test wrap-around: 20 interleaved write/read pairs with counting data -> output sequence identical to input, no flag glitches, usedw never exceeds 1.
REQ-040 SHALL test mid-operation reset: assert aclr_n=0 asynchronously at usedw=5 -> outputs at reset values before the next edge; the following write/read returns the new data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO: count width,
// parameter legality and the registered status-flag bundle.
package fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_flags_t;

    // Bits needed to count 0..2**log_depth inclusive.
    function automatic int count_width(input int log_depth);
        return $clog2((1 << log_depth) + 1);
    endfunction

    function automatic bit thresholds_ok(input int log_depth, input int af, input int ae);
        return (af <= (1 << log_depth)) && (ae <= af) && (ae >= 0);
    endfunction

    function automatic fifo_flags_t flags_for(input int count, input int depth,
                                              input int af, input int ae);
        fifo_flags_t f;
        f.empty        = (count == 0);
        f.full         = (count == depth);
        f.almost_empty = (count < ae);
        f.almost_full  = (count >= af);
        return f;
    endfunction

endpackage

// File: rtl/generic_mlab_sc.sv
// Single-clock simple-dual-port RAM; the read port is registered and its
// output register (not the array) is cleared by reset and sclr.
module generic_mlab_sc #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              sclr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // A read of the address being written returns the old word.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)     rdata <= '0;
        else if (sclr)   rdata <= '0;
        else if (re)     rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_sa.sv
// Single-clock FIFO with registered flags, sticky error flags and an optional
// show-ahead (first-word-fall-through) read port with write-through bypass.
module sync_fifo_sa
    import fifo_pkg::*;
#(
    parameter int LOG_DEPTH          = 3,
    parameter int WIDTH              = 8,
    parameter int ALMOST_FULL_VALUE  = 6,
    parameter int ALMOST_EMPTY_VALUE = 2,
    parameter int SHOW_AHEAD         = 0,
    parameter int OVERFLOW_CHECKING  = 1,
    parameter int UNDERFLOW_CHECKING = 1
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             sclr,
    input  logic             wrreq,
    input  logic [WIDTH-1:0] data,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LOG_DEPTH:0] usedw,
    output logic             overflow,
    output logic             underflow
);

    localparam int CW    = LOG_DEPTH + 1;
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam fifo_flags_t FLAGS_RST = '{empty: 1'b1, full: 1'b0,
                                          almost_empty: (ALMOST_EMPTY_VALUE > 0),
                                          almost_full: 1'b0};

    if (!thresholds_ok(LOG_DEPTH, ALMOST_FULL_VALUE, ALMOST_EMPTY_VALUE)
        || count_width(LOG_DEPTH) != CW) begin : g_bad_params
        $error("sync_fifo_sa: illegal almost_full/almost_empty thresholds");
    end

    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr, rd_ptr_next, ram_raddr;
    logic [CW-1:0]        usedw_next;
    logic                 rd_en, wr_en, ram_re, byp_load, byp_sel;
    logic [WIDTH-1:0]     ram_q, byp_data;
    fifo_flags_t          flags, flags_next;

    always_comb begin
        rd_en       = rdreq && (!flags.empty || UNDERFLOW_CHECKING == 0) && !sclr;
        wr_en       = wrreq && (!flags.full || rd_en || OVERFLOW_CHECKING == 0) && !sclr;
        usedw_next  = usedw + CW'(wr_en) - CW'(rd_en);
        rd_ptr_next = rd_en ? rd_ptr + LOG_DEPTH'(1) : rd_ptr;
        flags_next  = flags_for(int'(usedw_next), DEPTH, ALMOST_FULL_VALUE, ALMOST_EMPTY_VALUE);
        // Show-ahead keeps the RAM prefetching the head of the queue every cycle;
        // a word written straight into the head slot cannot come out of the RAM
        // in time, so it is captured on the side and muxed onto q.
        byp_load    = (SHOW_AHEAD != 0) && wr_en && (wr_ptr == rd_ptr_next);
        ram_re      = (SHOW_AHEAD != 0) ? 1'b1 : rd_en;
        ram_raddr   = (SHOW_AHEAD != 0) ? rd_ptr_next : rd_ptr;
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr <= '0; rd_ptr <= '0; usedw <= '0; flags <= FLAGS_RST;
            overflow <= 1'b0; underflow <= 1'b0; byp_sel <= 1'b0; byp_data <= '0;
        end else if (sclr) begin
            wr_ptr <= '0; rd_ptr <= '0; usedw <= '0; flags <= FLAGS_RST;
            overflow <= 1'b0; underflow <= 1'b0; byp_sel <= 1'b0; byp_data <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
            rd_ptr <= rd_ptr_next;
            usedw  <= usedw_next;
            flags  <= flags_next;
            if (wrreq && flags.full && !rdreq) overflow  <= 1'b1;
            if (rdreq && flags.empty)          underflow <= 1'b1;
            byp_sel <= byp_load;
            if (byp_load) byp_data <= data;
        end
    end

    generic_mlab_sc #(
        .ADDR_W (LOG_DEPTH),
        .DATA_W (WIDTH)
    ) u_ram (
        .clock  (clock),
        .aclr_n (aclr_n),
        .sclr   (sclr),
        .we     (wr_en),
        .waddr  (wr_ptr),
        .wdata  (data),
        .re     (ram_re),
        .raddr  (ram_raddr),
        .rdata  (ram_q)
    );

    assign q            = byp_sel ? byp_data : ram_q;
    assign empty        = flags.empty;
    assign full         = flags.full;
    assign almost_empty = flags.almost_empty;
    assign almost_full  = flags.almost_full;

endmodule

// File: tb/tb_sync_fifo_sa.sv
// Bench for sync_fifo_sa: a normal-mode and a show-ahead instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_sync_fifo_sa;

    logic       clock = 1'b0;
    logic       aclr_n = 1'b1;
    logic       sclr = 1'b0, wrreq = 1'b0, rdreq = 1'b0;
    logic [7:0] data = 8'h00;

    logic [7:0] q_n, q_sa;
    logic [3:0] usedw_n, usedw_sa;
    logic       empty_n, full_n, ae_n, af_n, ovf_n, unf_n;
    logic       empty_sa, full_sa, ae_sa, af_sa, ovf_sa, unf_sa;

    always #5 clock = ~clock;

    sync_fifo_sa #(.LOG_DEPTH(3), .WIDTH(8), .SHOW_AHEAD(0)) dut_n (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .wrreq(wrreq), .data(data),
        .rdreq(rdreq), .q(q_n), .empty(empty_n), .full(full_n),
        .almost_empty(ae_n), .almost_full(af_n), .usedw(usedw_n),
        .overflow(ovf_n), .underflow(unf_n));

    sync_fifo_sa #(.LOG_DEPTH(3), .WIDTH(8), .SHOW_AHEAD(1)) dut_sa (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .wrreq(wrreq), .data(data),
        .rdreq(rdreq), .q(q_sa), .empty(empty_sa), .full(full_sa),
        .almost_empty(ae_sa), .almost_full(af_sa), .usedw(usedw_sa),
        .overflow(ovf_sa), .underflow(unf_sa));

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the FIFO contents as a queue plus sticky flags.
    logic [7:0] mq[$];
    bit         m_ovf, m_unf;
    logic [7:0] m_qn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input logic [3:0] u, input logic e, f, ae, af,
                             ov, un, input logic [7:0] qv, input int eu, input bit ee, ef,
                             eae, eaf, eov, eun, input logic [7:0] eq, input bit chk_q);
        chk({tag, " usedw"}, u, eu);
        chk({tag, " empty"}, e, ee);
        chk({tag, " full"}, f, ef);
        chk({tag, " almost_empty"}, ae, eae);
        chk({tag, " almost_full"}, af, eaf);
        chk({tag, " overflow"}, ov, eov);
        chk({tag, " underflow"}, un, eun);
        if (chk_q) chk({tag, " q"}, qv, eq);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_qn  = 8'h00;
    endtask

    task automatic model_step(input bit wr, rd, sc, input logic [7:0] d);
        int cnt;
        bit e, f, ra, wa;
        cnt = mq.size();
        e   = (cnt == 0);
        f   = (cnt == 8);
        ra  = rd && !e;
        wa  = wr && (!f || ra);
        if (sc) begin
            model_reset();
        end else begin
            if (wr && f && !rd) m_ovf = 1'b1;
            if (rd && e)        m_unf = 1'b1;
            if (ra) m_qn = mq.pop_front();
            if (wa) mq.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        int cnt;
        cnt = mq.size();
        check_dut({tag, " norm"}, usedw_n, empty_n, full_n, ae_n, af_n, ovf_n, unf_n, q_n,
                  cnt, cnt == 0, cnt == 8, cnt < 2, cnt >= 6, m_ovf, m_unf, m_qn, 1'b1);
        check_dut({tag, " sa"}, usedw_sa, empty_sa, full_sa, ae_sa, af_sa, ovf_sa, unf_sa, q_sa,
                  cnt, cnt == 0, cnt == 8, cnt < 2, cnt >= 6, m_ovf, m_unf,
                  (cnt > 0) ? mq[0] : 8'h00, cnt > 0);
    endtask

    task automatic cycle(input bit wr, rd, sc, input logic [7:0] d, input string tag);
        wrreq = wr; rdreq = rd; sclr = sc; data = d;
        model_step(wr, rd, sc, d);
        @(posedge clock);
        #1;
        wrreq = 1'b0; rdreq = 1'b0; sclr = 1'b0;
        check_model(tag);
    endtask

    typedef struct {
        bit         wr, rd, sc;
        logic [7:0] d;
        int         usedw;
        bit         empty, full, ae, af, ovf, unf;
        logic [7:0] qn, qsa;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit wr, bit rd, bit sc, logic [7:0] d, int u, bit e, bit f,
                                bit ae, bit af, bit ov, bit un, logic [7:0] qn, logic [7:0] qsa);
        vec_t v;
        v.wr = wr; v.rd = rd; v.sc = sc; v.d = d; v.usedw = u;
        v.empty = e; v.full = f; v.ae = ae; v.af = af; v.ovf = ov; v.unf = un;
        v.qn = qn; v.qsa = qsa;
        return v;
    endfunction

    initial begin
        int max_u;
        //             wr rd sc  d      u  e  f ae af ov un  qn     qsa
        tbl.push_back(mk(1, 0, 0, 8'h01, 1, 0, 0, 1, 0, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h02, 2, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h03, 3, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h04, 4, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h05, 5, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h06, 6, 0, 0, 0, 1, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h07, 7, 0, 0, 0, 1, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'h08, 8, 0, 1, 0, 1, 0, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 0, 0, 8'hAA, 8, 0, 1, 0, 1, 1, 0, 8'h00, 8'h01));
        tbl.push_back(mk(1, 1, 0, 8'h09, 8, 0, 1, 0, 1, 1, 0, 8'h01, 8'h02));
        tbl.push_back(mk(0, 1, 0, 8'h00, 7, 0, 0, 0, 1, 1, 0, 8'h02, 8'h03));
        tbl.push_back(mk(0, 1, 0, 8'h00, 6, 0, 0, 0, 1, 1, 0, 8'h03, 8'h04));
        tbl.push_back(mk(0, 1, 0, 8'h00, 5, 0, 0, 0, 0, 1, 0, 8'h04, 8'h05));
        tbl.push_back(mk(0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 0, 8'h05, 8'h06));
        tbl.push_back(mk(0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 1, 0, 8'h06, 8'h07));
        tbl.push_back(mk(0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 0, 8'h07, 8'h08));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 0, 0, 1, 0, 1, 0, 8'h08, 8'h09));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 0, 8'h09, 8'h00));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 1, 1, 8'h09, 8'h00));
        tbl.push_back(mk(1, 1, 0, 8'h33, 1, 0, 0, 1, 0, 1, 1, 8'h09, 8'h33));
        tbl.push_back(mk(1, 0, 1, 8'h44, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(1, 0, 0, 8'h5C, 1, 0, 0, 1, 0, 0, 0, 8'h00, 8'h5C));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h5C, 8'h00));

        // Power-on reset: outputs take reset values without any clock edge.
        #2 aclr_n = 1'b0;
        model_reset();
        #2;
        check_dut("reset norm", usedw_n, empty_n, full_n, ae_n, af_n, ovf_n, unf_n, q_n,
                  0, 1, 0, 1, 0, 0, 0, 8'h00, 1'b1);
        check_dut("reset sa", usedw_sa, empty_sa, full_sa, ae_sa, af_sa, ovf_sa, unf_sa, q_sa,
                  0, 1, 0, 1, 0, 0, 0, 8'h00, 1'b1);
        @(negedge clock);
        aclr_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].wr, tbl[i].rd, tbl[i].sc, tbl[i].d, "tbl model");
            check_dut($sformatf("tbl[%0d] norm", i), usedw_n, empty_n, full_n, ae_n, af_n,
                      ovf_n, unf_n, q_n, tbl[i].usedw, tbl[i].empty, tbl[i].full, tbl[i].ae,
                      tbl[i].af, tbl[i].ovf, tbl[i].unf, tbl[i].qn, 1'b1);
            check_dut($sformatf("tbl[%0d] sa", i), usedw_sa, empty_sa, full_sa, ae_sa, af_sa,
                      ovf_sa, unf_sa, q_sa, tbl[i].usedw, tbl[i].empty, tbl[i].full, tbl[i].ae,
                      tbl[i].af, tbl[i].ovf, tbl[i].unf, tbl[i].qsa, !tbl[i].empty);
        end

        // Wrap-around: counting data through write/read pairs past the pointer wrap.
        max_u = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 8'(8'h10 + i), "wrap wr");
            if (int'(usedw_n) > max_u) max_u = int'(usedw_n);
            cycle(0, 1, 0, 8'h00, "wrap rd");
            if (int'(usedw_n) > max_u) max_u = int'(usedw_n);
            chk("wrap order", q_n, 8'(8'h10 + i));
        end
        chk("wrap usedw max", max_u, 1);

        // Asynchronous reset in the middle of operation at usedw=5.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'($urandom_range(0, 255)), "pre-reset fill");
        chk("pre-reset usedw", usedw_n, 5);
        #3 aclr_n = 1'b0;
        model_reset();
        #1;
        check_dut("mid reset norm", usedw_n, empty_n, full_n, ae_n, af_n, ovf_n, unf_n, q_n,
                  0, 1, 0, 1, 0, 0, 0, 8'h00, 1'b1);
        check_dut("mid reset sa", usedw_sa, empty_sa, full_sa, ae_sa, af_sa, ovf_sa, unf_sa, q_sa,
                  0, 1, 0, 1, 0, 0, 0, 8'h00, 1'b1);
        @(negedge clock);
        aclr_n = 1'b1;
        cycle(1, 0, 0, 8'h77, "post-reset wr");
        chk("post-reset sa q", q_sa, 8'h77);
        chk("post-reset usedw", usedw_n, 1);
        cycle(0, 1, 0, 8'h00, "post-reset rd");
        chk("post-reset norm q", q_n, 8'h77);

        // Randomized traffic with varying write/read bias and rare sclr.
        for (int ph = 0; ph < 4; ph++) begin
            int wr_pct;
            wr_pct = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            for (int i = 0; i < 200; i++) begin
                bit wr, rd, sc;
                wr = ($urandom_range(0, 99) < wr_pct);
                rd = ($urandom_range(0, 99) < (100 - wr_pct));
                sc = ($urandom_range(0, 99) == 0);
                cycle(wr, rd, sc, 8'($urandom_range(0, 255)), "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
